// File: rtl/mmuart_pkg.sv
// Shared definitions for the Milkymist UART: receiver FSM encoding and
// 16x-oversampling sample points.
package mmuart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_RECOVER = 3'd4
    } rx_state_t;

    localparam logic [3:0] START_SAMPLE = 4'd7;
    localparam logic [3:0] BIT_SAMPLE   = 4'd15;
    localparam int         DATA_BITS    = 8;

endpackage

// File: rtl/mmuart_enable16.sv
// Oversampling tick generator: one tick every `divisor` sys_clk cycles.
// Shared with the transmitter so both directions use identical bit timing.
module mmuart_enable16 (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [15:0] i_divisor,
    output logic        o_tick
);

    logic [15:0] r_cnt;

    // divisor=0 reloads 0xFFFF, giving the maximum period of 65536
    always_ff @(posedge sys_clk) begin
        if (sys_rst || r_cnt == 16'd0)
            r_cnt <= i_divisor - 16'd1;
        else
            r_cnt <= r_cnt - 16'd1;
    end

    assign o_tick = (r_cnt == 16'd0);

endmodule

// File: rtl/mmuart_rx.sv
// 8N1 UART receiver with 16x oversampling, mid-bit sampling, framing-error
// and break detection.
module mmuart_rx
    import mmuart_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        uart_rx,
    input  logic [15:0] divisor,
    output logic [7:0]  rx_data,
    output logic        rx_done,
    output logic        rx_frame_err,
    output logic        rx_break,
    output logic        rx_busy
);

    logic       w_tick;
    logic       r_sync1;
    logic       r_line;
    rx_state_t  r_state,    w_state_nx;
    logic [3:0] r_count16,  w_count16_nx;
    logic [2:0] r_bitcount, w_bitcount_nx;
    logic [7:0] r_shreg,    w_shreg_nx;
    logic [7:0] r_rx_data,  w_rx_data_nx;
    logic       r_done,     w_done_nx;
    logic       r_ferr,     w_ferr_nx;
    logic       r_brk,      w_brk_nx;

    mmuart_enable16 u_enable16 (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .i_divisor (divisor),
        .o_tick    (w_tick)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_sync1 <= 1'b1;
            r_line  <= 1'b1;
        end else begin
            r_sync1 <= uart_rx;
            r_line  <= r_sync1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= ST_IDLE;
            r_count16  <= 4'd0;
            r_bitcount <= 3'd0;
            r_shreg    <= 8'd0;
            r_rx_data  <= 8'd0;
            r_done     <= 1'b0;
            r_ferr     <= 1'b0;
            r_brk      <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_count16  <= w_count16_nx;
            r_bitcount <= w_bitcount_nx;
            r_shreg    <= w_shreg_nx;
            r_rx_data  <= w_rx_data_nx;
            r_done     <= w_done_nx;
            r_ferr     <= w_ferr_nx;
            r_brk      <= w_brk_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_count16_nx  = r_count16;
        w_bitcount_nx = r_bitcount;
        w_shreg_nx    = r_shreg;
        w_rx_data_nx  = r_rx_data;
        w_done_nx     = 1'b0;
        w_ferr_nx     = 1'b0;
        w_brk_nx      = 1'b0;
        if (w_tick) begin
            if (r_state != ST_IDLE && r_state != ST_RECOVER)
                w_count16_nx = r_count16 + 4'd1;
            case (r_state)
                ST_IDLE: begin
                    if (!r_line) begin
                        w_state_nx   = ST_START;
                        w_count16_nx = 4'd0;
                    end
                end
                ST_START: begin
                    if (r_count16 == START_SAMPLE) begin
                        if (r_line) begin
                            w_state_nx = ST_IDLE;
                        end else begin
                            w_state_nx    = ST_DATA;
                            w_count16_nx  = 4'd0;
                            w_bitcount_nx = 3'd0;
                        end
                    end
                end
                ST_DATA: begin
                    // count16 wraps 15->0, so the next bit is 16 ticks later
                    if (r_count16 == BIT_SAMPLE) begin
                        w_shreg_nx    = {r_line, r_shreg[7:1]};
                        w_bitcount_nx = r_bitcount + 3'd1;
                        if (r_bitcount == 3'(DATA_BITS - 1))
                            w_state_nx = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (r_count16 == BIT_SAMPLE) begin
                        if (r_line) begin
                            w_rx_data_nx = r_shreg;
                            w_done_nx    = 1'b1;
                            w_state_nx   = ST_IDLE;
                        end else begin
                            w_ferr_nx  = 1'b1;
                            w_brk_nx   = (r_shreg == 8'd0);
                            w_state_nx = ST_RECOVER;
                        end
                    end
                end
                ST_RECOVER: begin
                    // hold off until the line goes idle so a stuck-low line
                    // is not seen as a new start bit
                    if (r_line)
                        w_state_nx = ST_IDLE;
                end
                default: w_state_nx = ST_IDLE;
            endcase
        end
    end

    assign rx_data      = r_rx_data;
    assign rx_done      = r_done;
    assign rx_frame_err = r_ferr;
    assign rx_break     = r_brk;
    assign rx_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mmuart_rx.sv
// Scoreboard bench for mmuart_rx: serial frames driven on uart_rx, expected
// receive events queued and matched against output pulses.
module tb_mmuart_rx;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        uart_rx = 1'b1;
    logic [15:0] divisor = 16'd4;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        rx_frame_err;
    logic        rx_break;
    logic        rx_busy;

    typedef struct packed {
        logic [1:0] kind;   // {frame_err, done}
        logic [7:0] data;
        logic       brk;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   t_start = 0;
    int   t_done  = 0;
    int   bitp    = 64;

    mmuart_rx dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .uart_rx      (uart_rx),
        .divisor      (divisor),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .rx_frame_err (rx_frame_err),
        .rx_break     (rx_break),
        .rx_busy      (rx_busy)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge sys_clk) begin
        exp_t e;
        if (rx_break && !rx_frame_err)
            chk("break_alone", 32'(rx_break), 32'd0);
        if (rx_done || rx_frame_err) begin
            if (rx_done) t_done = cyc;
            if (sbq.size() == 0) begin
                chk("unexpected_pulse", {30'd0, rx_frame_err, rx_done}, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("pulse_kind", {30'd0, rx_frame_err, rx_done}, {30'd0, e.kind});
                chk("rx_data",    32'(rx_data),  32'(e.data));
                chk("rx_break",   32'(rx_break), 32'(e.brk));
            end
        end
    end

    task automatic push(input logic [1:0] kind, input logic [7:0] data, input logic brk);
        exp_t e;
        e.kind = kind;
        e.data = data;
        e.brk  = brk;
        sbq.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge sys_clk);
        uart_rx = 1'b0;
        t_start = cyc;
        repeat (bitp - 1) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge sys_clk);
            uart_rx = b[i];
            repeat (bitp - 1) @(negedge sys_clk);
        end
        @(negedge sys_clk);
        uart_rx = stop;
        repeat (bitp - 1) @(negedge sys_clk);
    endtask

    task automatic wait_idle(input string tag);
        int i;
        for (i = 0; i < 4000; i++) begin
            @(negedge sys_clk);
            if (!rx_busy && sbq.size() == 0) break;
        end
        repeat (2) @(negedge sys_clk);
        chk(tag, {30'd0, rx_busy, 1'(sbq.size() != 0)}, 32'd0);
    endtask

    task automatic do_reset(input logic [15:0] d);
        @(negedge sys_clk);
        divisor = d;
        bitp    = 16 * ((d == 16'd0) ? 65536 : int'(d));
        sys_rst = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    task automatic rst_midframe(input logic [15:0] d);
        logic [7:0] b;
        b = 8'hF0;
        do_reset(d);
        repeat (bitp) @(negedge sys_clk);
        uart_rx = 1'b0;
        repeat (bitp) @(negedge sys_clk);
        for (int i = 0; i < 4; i++) begin
            uart_rx = b[i];
            repeat (bitp) @(negedge sys_clk);
        end
        uart_rx = b[4];
        repeat (bitp / 2) @(negedge sys_clk);
        chk("busy_before_rst", 32'(rx_busy), 32'd1);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        chk("busy_after_rst", 32'(rx_busy), 32'd0);
        chk("data_after_rst", 32'(rx_data), 32'd0);
        sys_rst = 1'b0;
        uart_rx = 1'b1;
        repeat (bitp * 6) @(negedge sys_clk);
        push(2'b01, 8'h42, 1'b0);
        send_byte(8'h42, 1'b1);
        wait_idle("rst_recover_idle");
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        do_reset(16'd4);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        chk("rst_data",  32'(rx_data),      32'd0);
        chk("rst_done",  32'(rx_done),      32'd0);
        chk("rst_ferr",  32'(rx_frame_err), 32'd0);
        chk("rst_break", 32'(rx_break),     32'd0);
        chk("rst_busy",  32'(rx_busy),      32'd0);
        sys_rst = 1'b0;
        repeat (20) @(negedge sys_clk);

        // single frame and detection-to-done latency (152 ticks of 4 cycles)
        push(2'b01, 8'h55, 1'b0);
        send_byte(8'h55, 1'b1);
        wait_idle("idle_55");
        lat = t_done - t_start;
        chk("latency_window", 32'((lat >= 606) && (lat <= 618)), 32'd1);

        // back-to-back, no idle gap
        push(2'b01, 8'hA5, 1'b0);
        push(2'b01, 8'h00, 1'b0);
        push(2'b01, 8'hFF, 1'b0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        wait_idle("idle_b2b");

        // 2-tick glitch: START entered, rejected at T8
        @(negedge sys_clk);
        uart_rx = 1'b0;
        repeat (8) @(negedge sys_clk);
        uart_rx = 1'b1;
        repeat (4) @(negedge sys_clk);
        chk("glitch_busy", 32'(rx_busy), 32'd1);
        repeat (40) @(negedge sys_clk);
        chk("glitch_idle", 32'(rx_busy), 32'd0);

        // framing error: rx_data keeps 0xFF, waits in RECOVER while low
        push(2'b10, 8'hFF, 1'b0);
        send_byte(8'h3C, 1'b0);
        repeat (2 * bitp) @(negedge sys_clk);
        chk("recover_busy", 32'(rx_busy), 32'd1);
        uart_rx = 1'b1;
        wait_idle("idle_ferr");

        // break: line held low 20 bit times, one error pulse only
        push(2'b10, 8'hFF, 1'b1);
        @(negedge sys_clk);
        uart_rx = 1'b0;
        repeat (20 * bitp) @(negedge sys_clk);
        chk("break_busy", 32'(rx_busy), 32'd1);
        uart_rx = 1'b1;
        wait_idle("idle_break");
        push(2'b01, 8'h81, 1'b0);
        send_byte(8'h81, 1'b1);
        wait_idle("idle_81");

        rst_midframe(16'd4);
        rst_midframe(16'd1);

        // divisor=0: period 65536, so no tick well after reset
        do_reset(16'd0);
        uart_rx = 1'b0;
        repeat (3000) @(negedge sys_clk);
        chk("div0_no_tick", 32'(rx_busy), 32'd0);
        uart_rx = 1'b1;
        do_reset(16'd4);
        repeat (4) @(negedge sys_clk);
        chk("final_queue", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
